// File: rtl/anim_sequencer_if.sv
// rtl/anim_sequencer_if.sv - pixel, control and ROM bus between the VGA path and the animation sequencer
interface anim_sequencer_if #(
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned COLOR_W = 12
);
    logic [11:0]        x;
    logic [11:0]        y;
    logic               start;
    logic               pause;
    logic [1:0]         mode;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [COLOR_W-1:0] color_data;
    logic [IDX_W-1:0]   frame_idx;
    logic               frame_tick;
    logic               done;
    logic               busy;

    modport master (
        output x, y, start, pause, mode, rom_data,
        input  rom_addr, color_data, frame_idx, frame_tick, done, busy
    );

    modport slave (
        input  x, y, start, pause, mode, rom_data,
        output rom_addr, color_data, frame_idx, frame_tick, done, busy
    );
endinterface

// File: rtl/anim_sequencer.sv
// rtl/anim_sequencer.sv - full-screen sprite animation sequencer (loop/ping-pong/one-shot) feeding VGA colour
// Optional macro ANIM_BLANK_FRAME_EN appends a virtual FILL_COLOR frame after the last stored frame.
module anim_sequencer #(
    parameter int unsigned         N_FRAMES     = 21,
    parameter int unsigned         FRAME_PERIOD = 2097152,
    parameter int unsigned         SCALE_SHIFT  = 4,
    parameter int unsigned         COL_W        = 6,
    parameter int unsigned         ROW_W        = 6,
    parameter int unsigned         ACTIVE_W     = 1024,
    parameter int unsigned         ACTIVE_H     = 1024,
    parameter int unsigned         COLOR_W      = 12,
    parameter logic [COLOR_W-1:0]  FILL_COLOR   = 12'hFFF
) (
    input  logic           vgaClk,
    input  logic           rst,
    anim_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_FRAMES + 1);
    localparam int unsigned DIV_W = $clog2(FRAME_PERIOD);
`ifdef ANIM_BLANK_FRAME_EN
    localparam int unsigned LAST_I = N_FRAMES;
`else
    localparam int unsigned LAST_I = N_FRAMES - 1;
`endif
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(LAST_I);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(FRAME_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_HOLD} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   disp_q;
    logic [DIV_W-1:0]   div_q;
    logic               dir_q;
    logic               tick_q;
    logic               done_q;
    logic               busy_q;
    logic               act_q;
    logic               blank_q;
    logic [COLOR_W-1:0] color_q;

    logic [IDX_W-1:0]   idx_d;
    logic               dir_d;
    logic               finish_d;
    logic               blank_d;

    // Next index for the coming tick; dir_q=1 means counting down in ping-pong.
    always_comb begin
        idx_d    = idx_q;
        dir_d    = dir_q;
        finish_d = 1'b0;
        case (bus.mode)
            2'b01: begin
                if (LAST == '0) begin
                    idx_d = '0;
                end else if (!dir_q) begin
                    if (idx_q == LAST) begin
                        dir_d = 1'b1;
                        idx_d = idx_q - 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    if (idx_q == '0) begin
                        dir_d = 1'b0;
                        idx_d = IDX_W'(1);
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            2'b10: begin
                if (idx_q == LAST) begin
                    finish_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                dir_d = 1'b0;
                idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
            end
        endcase
    end

    always_ff @(posedge vgaClk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            div_q   <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.start) begin
                state_q <= S_PLAY;
                idx_q   <= '0;
                dir_q   <= 1'b0;
                div_q   <= '0;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_PLAY, S_PAUSE: begin
                        if (bus.pause) begin
                            state_q <= S_PAUSE;
                        end else begin
                            state_q <= S_PLAY;
                            if (div_q == DIV_MAX) begin
                                div_q  <= '0;
                                tick_q <= 1'b1;
                                idx_q  <= idx_d;
                                dir_q  <= dir_d;
                                if (finish_d) begin
                                    state_q <= S_HOLD;
                                    done_q  <= 1'b1;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                div_q <= div_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ANIM_BLANK_FRAME_EN
    assign blank_d = (disp_q == IDX_W'(N_FRAMES));
`else
    assign blank_d = 1'b0;
`endif

    // disp_q only follows idx_q at the top-left pixel so a frame never changes mid-scan.
    always_ff @(posedge vgaClk) begin
        if (rst) begin
            disp_q  <= '0;
            act_q   <= 1'b0;
            blank_q <= 1'b0;
            color_q <= FILL_COLOR;
        end else begin
            if (bus.x == '0 && bus.y == '0) begin
                disp_q <= idx_q;
            end
            act_q   <= (32'(bus.x) < ACTIVE_W) && (32'(bus.y) < ACTIVE_H);
            blank_q <= blank_d;
            color_q <= (state_q != S_IDLE && act_q && !blank_q) ? bus.rom_data : FILL_COLOR;
        end
    end

    assign bus.rom_addr   = {disp_q, bus.y[SCALE_SHIFT +: ROW_W], bus.x[SCALE_SHIFT +: COL_W]};
    assign bus.color_data = color_q;
    assign bus.frame_idx  = idx_q;
    assign bus.frame_tick = tick_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_anim_sequencer.sv
// tb/tb_anim_sequencer.sv - scoreboard bench for anim_sequencer with a frame-sequence reference model
module tb_anim_sequencer;
    localparam int NF     = 3;
    localparam int FP     = 4;
    localparam int IDX_W  = 2;
    localparam int ADDR_W = 14;
    localparam int CW     = 12;
    localparam logic [11:0] FILL = 12'hFFF;
`ifdef ANIM_BLANK_FRAME_EN
    localparam int LAST  = NF;
    localparam bit BLANK = 1'b1;
`else
    localparam int LAST  = NF - 1;
    localparam bit BLANK = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] color;
        logic        tick;
        logic        done;
        logic        busy;
        logic [1:0]  idx;
    } exp_t;

    logic vgaClk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    anim_sequencer_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .COLOR_W(CW)) bus ();

    anim_sequencer #(.N_FRAMES(NF), .FRAME_PERIOD(FP)) dut (
        .vgaClk (vgaClk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 vgaClk = ~vgaClk;

    function automatic logic [11:0] rom_fn(input logic [13:0] a);
        logic [31:0] t;
        t = {18'd0, a} * 32'd2741 + 32'd97;
        return t[11:0] ^ t[23:12];
    endfunction

    always @(posedge vgaClk) bus.rom_data <= rom_fn(bus.rom_addr);

    // Reference: state 0 idle, 1 play, 2 pause, 3 hold; m_p is the ping-pong phase over 2*LAST steps.
    int          m_st, m_idx, m_p, m_cnt, m_disp;
    bit          pv_act, pv_blank;
    logic [13:0] pv_addr;

    always @(posedge vgaClk) begin
        exp_t e;
        int   xi, yi;
        cyc++;
        xi = int'(bus.x);
        yi = int'(bus.y);
        e  = '0;
        if (rst) begin
            m_st = 0; m_idx = 0; m_p = 0; m_cnt = 0; m_disp = 0;
            pv_act = 1'b0; pv_blank = 1'b0; pv_addr = '0;
            e.color = FILL;
        end else begin
            e.color  = (m_st != 0 && pv_act && !pv_blank) ? rom_fn(pv_addr) : FILL;
            pv_addr  = {2'(m_disp), bus.y[9:4], bus.x[9:4]};
            pv_act   = (xi < 1024) && (yi < 1024);
            pv_blank = BLANK && (m_disp == NF);
            if (xi == 0 && yi == 0) m_disp = m_idx;
            if (bus.start) begin
                m_st = 1; m_idx = 0; m_p = 0; m_cnt = 0;
            end else if (m_st == 1 || m_st == 2) begin
                if (bus.pause) begin
                    m_st = 2;
                end else begin
                    m_st = 1;
                    m_cnt++;
                    if (m_cnt == FP) begin
                        m_cnt  = 0;
                        e.tick = 1'b1;
                        if (bus.mode == 2'b10) begin
                            if (m_idx == LAST) begin
                                m_st   = 3;
                                e.done = 1'b1;
                            end else begin
                                m_idx++;
                            end
                            m_p = m_idx;
                        end else if (bus.mode == 2'b01) begin
                            if (LAST == 0) begin
                                m_idx = 0;
                            end else begin
                                m_p   = (m_p + 1) % (2 * LAST);
                                m_idx = (m_p <= LAST) ? m_p : 2 * LAST - m_p;
                            end
                        end else begin
                            m_idx = (m_idx + 1) % (LAST + 1);
                            m_p   = m_idx;
                        end
                    end
                end
            end
        end
        e.busy = (m_st == 1 || m_st == 2);
        e.idx  = 2'(m_idx);
        exp_q.push_back(e);
    end

    always @(negedge vgaClk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (bus.color_data !== e.color) begin
                n_fail++;
                $display("FAIL color cyc=%0d got=%h exp=%h", cyc, bus.color_data, e.color);
            end
            n_chk++;
            if ({bus.frame_tick, bus.done, bus.busy, bus.frame_idx} !== {e.tick, e.done, e.busy, e.idx}) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got tick=%b done=%b busy=%b idx=%0d exp tick=%b done=%b busy=%b idx=%0d",
                         cyc, bus.frame_tick, bus.done, bus.busy, bus.frame_idx, e.tick, e.done, e.busy, e.idx);
            end
        end
    end

    task automatic rand_pix();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: begin bus.x = 12'd0;    bus.y = 12'd0; end
            1: begin bus.x = 12'd1023; bus.y = 12'($urandom_range(0, 1100)); end
            2: begin bus.x = 12'd1024; bus.y = 12'($urandom_range(0, 1100)); end
            3: begin bus.x = 12'($urandom_range(0, 1100)); bus.y = 12'(1023 + $urandom_range(0, 1)); end
            default: begin bus.x = 12'($urandom_range(0, 4095)); bus.y = 12'($urandom_range(0, 1100)); end
        endcase
    endtask

    task automatic step(input bit s, input bit p, input logic [1:0] m);
        @(negedge vgaClk);
        bus.start = s;
        bus.pause = p;
        bus.mode  = m;
        rand_pix();
    endtask

    initial begin
        logic [1:0] mode_cur;
        bit         pause_cur;
        int         r;
        rst = 1'b1;
        bus.start = 1'b0; bus.pause = 1'b0; bus.mode = 2'b00;
        bus.x = 12'd0; bus.y = 12'd0;
        repeat (3) @(negedge vgaClk);
        rst = 1'b0;
        step(1, 0, 2'b00); repeat (24) step(0, 0, 2'b00);
        step(1, 0, 2'b01); repeat (30) step(0, 0, 2'b01);
        step(1, 0, 2'b10); repeat (20) step(0, 0, 2'b10);
        step(1, 0, 2'b10); repeat (5) step(0, 0, 2'b10);
        step(1, 0, 2'b00); step(0, 0, 2'b00);
        repeat (10) step(0, 1, 2'b00);
        repeat (8) step(0, 0, 2'b00);
        repeat (3) step(0, 1, 2'b00);
        step(1, 1, 2'b00); repeat (6) step(0, 0, 2'b00);
        @(negedge vgaClk); bus.start = 1'b0; bus.x = 12'd1023; bus.y = 12'd5;
        @(negedge vgaClk); bus.x = 12'd1024;
        @(negedge vgaClk); bus.x = 12'd0; bus.y = 12'd0;
        repeat (3) @(negedge vgaClk);
        mode_cur  = 2'b00;
        pause_cur = 1'b0;
        repeat (3000) begin
            r = $urandom_range(0, 199);
            @(negedge vgaClk);
            rst       = (r == 0);
            bus.start = (r < 5);
            if (r < 5) begin
                mode_cur = 2'($urandom_range(0, 3));
            end else if (r < 9 && mode_cur != 2'b10) begin
                mode_cur = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            end
            if ($urandom_range(0, 19) == 0) pause_cur = ~pause_cur;
            bus.pause = pause_cur;
            bus.mode  = mode_cur;
            rand_pix();
        end
        @(negedge vgaClk);
        rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
        repeat (4) @(negedge vgaClk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
